wb_register_file: RTL

//   Write-back stage plus architectural register file: consumer end of the MEM/WB pipeline register.

---
 rtl/wb_register_file.sv | 55 +++++
 1 files changed

// File: rtl/wb_register_file.sv
// Write-back stage and architectural register file: selects the WB value, commits it, and serves two ID read ports.
// Optional write-through bypass on the read ports is enabled by defining WB_BYPASS_EN.
module wb_register_file #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  read_data_wb,
  input  logic [DATA_WIDTH-1:0]  alu_result_wb,
  input  logic [ADDR_WIDTH-1:0]  rd_wb,
  input  logic                   MemtoReg_wb,
  input  logic                   RegWrite_wb,
  input  logic [ADDR_WIDTH-1:0]  rs1_id,
  input  logic [ADDR_WIDTH-1:0]  rs2_id,
  output logic [DATA_WIDTH-1:0]  read_data1_id,
  output logic [DATA_WIDTH-1:0]  read_data2_id,
  output logic [DATA_WIDTH-1:0]  wb_data,
  output logic [COUNT_WIDTH-1:0] wb_write_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  commit;

  assign wb_data = MemtoReg_wb ? read_data_wb : alu_result_wb;

  // Reset outranks a simultaneous write; index 0 is never written so it stays zero.
  assign commit = !reset && RegWrite_wb && (rd_wb != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wb_write_count <= '0;
    end else if (commit) begin
      regs[rd_wb]    <= wb_data;
      wb_write_count <= wb_write_count + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    read_data1_id = (rs1_id == '0) ? '0 : regs[rs1_id];
    read_data2_id = (rs2_id == '0) ? '0 : regs[rs2_id];
`ifdef WB_BYPASS_EN
    // Write-through: the committing value is visible to ID in the same cycle.
    if (commit && (rs1_id == rd_wb)) read_data1_id = wb_data;
    if (commit && (rs2_id == rd_wb)) read_data2_id = wb_data;
`endif
  end

endmodule
